bch_encode_serial: RTL and testbench

Bit-serial systematic BCH encoder, the transmit-side counterpart of the parallel inversionless decoder. It accepts K message bits on a ready/valid stream and passes them straight through, MSB (highest-degree coefficient) first. It then appends the P = N-K parity bits held in a generator-polynomial LFSR. Its output feeds the channel model and the syndrome/decoder chain in the BCH test harness.

---
 rtl/bch_encode_serial_if.sv | 34 +++
 rtl/bch_encode_serial.sv | 202 ++++++++++++++++++++
 tb/tb_bch_encode_serial.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bch_encode_serial_if.sv
// Stream bundle for the bit-serial BCH encoder.
// Carries the message input stream (s_*) and the codeword output stream (o_*).
// The s_last signal exists only when BCH_ENCODE_SHORTEN_EN is defined.
// master: the environment, which feeds message bits and consumes codeword bits.
// slave:  the encoder itself.
interface bch_encode_serial_if;
  logic s_valid;
  logic s_ready;
  logic s_data;
`ifdef BCH_ENCODE_SHORTEN_EN
  logic s_last;
`endif
  logic o_valid;
  logic o_ready;
  logic o_data;
  logic o_first;
  logic o_last;

  modport master (
`ifdef BCH_ENCODE_SHORTEN_EN
    output s_last,
`endif
    output s_valid, s_data, o_ready,
    input  s_ready, o_valid, o_data, o_first, o_last
  );

  modport slave (
`ifdef BCH_ENCODE_SHORTEN_EN
    input  s_last,
`endif
    input  s_valid, s_data, o_ready,
    output s_ready, o_valid, o_data, o_first, o_last
  );
endinterface

// File: rtl/bch_encode_serial.sv
// Bit-serial systematic BCH encoder over GF(2^M), correcting T errors.
// Message bits pass straight through MSB first with no latency, while a
// generator-polynomial LFSR accumulates the remainder. The P parity bits
// are then shifted out of the LFSR.
// Optional feature macro: BCH_ENCODE_SHORTEN_EN adds s_last so that a word
// can end early, which gives a shortened code.
// The generator polynomial is derived at elaboration time. This supports M up to 8.
module bch_encode_serial #(
  parameter int M = 4,
  parameter int T = 3
) (
  input  logic clk,
  input  logic reset,
  bch_encode_serial_if.slave bus
);

  localparam int N = (1 << M) - 1;

  // Primitive polynomial used to build GF(2^m).
  function automatic logic [8:0] gfPrim(input int m);
    case (m)
      2:       gfPrim = 9'h007;
      3:       gfPrim = 9'h00B;
      4:       gfPrim = 9'h013;
      5:       gfPrim = 9'h025;
      6:       gfPrim = 9'h043;
      7:       gfPrim = 9'h089;
      default: gfPrim = 9'h11D;
    endcase
  endfunction

  // Multiply two GF(2^m) elements by shift-and-add with modular reduction.
  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b, input int m);
    logic [8:0] p;
    logic [8:0] prim;
    p = '0;
    prim = gfPrim(m);
    for (int i = 7; i >= 0; i--) begin
      if (i < m) begin
        p = p << 1;
        if (p[m]) p = p ^ prim;
        if (b[i]) p = p ^ {1'b0, a};
      end
    end
    return p[7:0];
  endfunction

  // Collect the exponents r of the roots alpha^r of g(x).
  // These are the union of the cyclotomic cosets of 1..2T.
  function automatic logic [255:0] bchRoots(input int m, input int t);
    logic [255:0] roots;
    int n;
    int k;
    n = (1 << m) - 1;
    roots = '0;
    for (int i = 1; i <= 2 * t; i++) begin
      k = i % n;
      for (int s = 0; s < m; s++) begin
        roots[k] = 1'b1;
        k = (k * 2) % n;
      end
    end
    return roots;
  endfunction

  // The degree of g equals the number of distinct roots.
  function automatic int bchDeg(input int m, input int t);
    logic [255:0] roots;
    int d;
    roots = bchRoots(m, t);
    d = 0;
    for (int r = 0; r < 256; r++) if (roots[r]) d++;
    return d;
  endfunction

  // Build g(x) as the product of (x + alpha^r) over all roots.
  // The coefficients collapse to GF(2).
  function automatic logic [255:0] bchGen(input int m, input int t);
    logic [255:0]  roots;
    logic [2047:0] c;
    logic [7:0]    a;
    logic [7:0]    prev;
    logic [7:0]    cur;
    logic [255:0]  g;
    int n;
    int deg;
    n = (1 << m) - 1;
    roots = bchRoots(m, t);
    c = '0;
    c[7:0] = 8'd1;
    deg = 0;
    a = 8'd1;
    for (int r = 0; r < n; r++) begin
      if (roots[r]) begin
        prev = 8'd0;
        for (int j = 0; j <= deg + 1; j++) begin
          cur = c[j*8 +: 8];
          c[j*8 +: 8] = prev ^ gfMul(cur, a, m);
          prev = cur;
        end
        deg++;
      end
      a = gfMul(a, 8'd2, m);
    end
    g = '0;
    for (int j = 0; j <= deg; j++) g[j] = c[j*8];
    return g;
  endfunction

  localparam logic [255:0] GFULL = bchGen(M, T);
  localparam int P    = bchDeg(M, T);
  localparam int K    = N - P;
  localparam int CMAX = (K > P) ? K : P;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [P-1:0]  G     = GFULL[P-1:0];
  localparam logic [CW-1:0] KLAST = CW'(K - 1);
  localparam logic [CW-1:0] PLAST = CW'(P - 1);

  typedef enum logic {DATA, PARITY} state_t;

  state_t         state_q, state_d;
  logic [P-1:0]   lfsr_q, lfsr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           sReady, oValid, oData, oFirst, oLast;
  logic           fb;
  logic           lastBeat;

  // Next-state and stream outputs. Data beats are combinational pass-through.
  // Parity beats come from the LFSR MSB.
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q;
    sReady   = 1'b0;
    oValid   = 1'b0;
    oData    = 1'b0;
    oFirst   = 1'b0;
    oLast    = 1'b0;
    fb       = bus.s_data ^ lfsr_q[P-1];
`ifdef BCH_ENCODE_SHORTEN_EN
    lastBeat = (cnt_q == KLAST) || bus.s_last;
`else
    lastBeat = (cnt_q == KLAST);
`endif
    case (state_q)
      DATA: begin
        oValid = bus.s_valid;
        sReady = bus.o_ready;
        oData  = bus.s_data;
        oFirst = (cnt_q == '0);
        if (bus.s_valid && bus.o_ready) begin
          lfsr_d = {lfsr_q[P-2:0], 1'b0} ^ (fb ? G : '0);
          if (lastBeat) begin
            state_d = PARITY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      PARITY: begin
        oValid = 1'b1;
        oData  = lfsr_q[P-1];
        oLast  = (cnt_q == PLAST);
        if (bus.o_ready) begin
          if (cnt_q == PLAST) begin
            state_d = DATA;
            lfsr_d  = '0;
            cnt_d   = '0;
          end else begin
            lfsr_d = {lfsr_q[P-2:0], 1'b0};
            cnt_d  = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = DATA;
    endcase
  end

  // Handshake outputs are held low for as long as reset is asserted.
  always_comb begin
    bus.s_ready = sReady & ~reset;
    bus.o_valid = oValid & ~reset;
    bus.o_first = oFirst & ~reset;
    bus.o_last  = oLast  & ~reset;
    bus.o_data  = oData;
  end

  // State registers. An asynchronous reset aborts any word in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= DATA;
      lfsr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bch_encode_serial.sv
// Testbench for bch_encode_serial with M=4 and T=3, giving a (15,5) code with g = 0x537.
// The reference codeword is computed by polynomial long division of m(x)*x^P.
module tb_bch_encode_serial;
  localparam int M = 4;
  localparam int T = 3;
  localparam int N = 15;
  localparam int K = 5;
  localparam int P = 10;
  localparam int GPOLY = 'h537;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bch_encode_serial_if bus();

  bch_encode_serial #(.M(M), .T(T)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  bit msgQ[$];
  bit lastQ[$];
  bit outBits[$];
  bit outFirst[$];
  bit outLast[$];
  bit throttle = 1'b0;
  int cycles;
  int done;
  int msgs[100];

  // Record every accepted codeword beat.
  always @(negedge clk) begin
    if (!reset && bus.o_valid && bus.o_ready) begin
      outBits.push_back(bus.o_data);
      outFirst.push_back(bus.o_first);
      outLast.push_back(bus.o_last);
    end
  end

  // Remainder of v(x) modulo g(x), where v has the given number of coefficients.
  function automatic int polyMod(input int v, input int width);
    int r;
    r = v;
    for (int b = width - 1; b >= P; b--) if (r[b]) r = r ^ (GPOLY << (b - P));
    return r;
  endfunction

  function automatic int refCodeword(input int msg);
    return (msg << P) | polyMod(msg << P, N);
  endfunction

  // Pack len captured beats starting at base; beat 0 lands in the MSB.
  function automatic int packBits(input int base, input int len, input int which);
    int v;
    v = 0;
    for (int i = 0; i < len; i++) begin
      if (which == 0) v = (v << 1) | int'(outBits[base + i]);
      else if (which == 1) v = (v << 1) | int'(outFirst[base + i]);
      else v = (v << 1) | int'(outLast[base + i]);
    end
    return v;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic loadWord(input int msg, input int nbits, input int lastAt);
    for (int i = nbits - 1; i >= 0; i--) begin
      msgQ.push_back(msg[i]);
      lastQ.push_back(i == lastAt);
    end
  endtask

  task automatic clearQueues();
    msgQ.delete();
    lastQ.delete();
    outBits.delete();
    outFirst.delete();
    outLast.delete();
  endtask

  // Stream queued message bits until numOut codeword beats have been seen.
  task automatic applyStimulus(input int numOut, input int budget);
    bit pending;
    pending = 1'b0;
    cycles = 0;
    done = 0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      #1;
      if (outBits.size() >= numOut) begin
        done = 1;
        break;
      end
      cycles++;
      bus.o_ready = throttle ? ($urandom_range(3) != 0) : 1'b1;
      if (!pending) begin
        if (msgQ.size() > 0 && (!throttle || $urandom_range(2) != 0)) begin
          bus.s_valid = 1'b1;
          bus.s_data  = msgQ[0];
`ifdef BCH_ENCODE_SHORTEN_EN
          bus.s_last  = lastQ[0];
`endif
        end else begin
          bus.s_valid = 1'b0;
        end
      end
      @(negedge clk);
      if (bus.s_valid && bus.s_ready) begin
        void'(msgQ.pop_front());
        void'(lastQ.pop_front());
        pending = 1'b0;
      end else begin
        pending = bus.s_valid;
      end
    end
    bus.s_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = 1'b0;
    bus.o_ready = 1'b0;
`ifdef BCH_ENCODE_SHORTEN_EN
    bus.s_last  = 1'b0;
`endif
    $display("[TB] start M=%0d T=%0d", M, T);

    // Outputs must be forced low while reset is held, even when inputs are active.
    repeat (2) @(posedge clk);
    #1;
    bus.s_valid = 1'b1;
    bus.s_data  = 1'b1;
    bus.o_ready = 1'b1;
    #1;
    checkOutput("rst_s_ready", int'(bus.s_ready), 0);
    checkOutput("rst_o_valid", int'(bus.o_valid), 0);
    checkOutput("rst_o_first", int'(bus.o_first), 0);
    checkOutput("rst_o_last",  int'(bus.o_last), 0);
    @(negedge clk);
    bus.s_valid = 1'b0;
    reset = 1'b0;
    #1;
    checkOutput("idle_o_valid", int'(bus.o_valid), 0);
    checkOutput("idle_o_first", int'(bus.o_first), 1);

    // All-zero message.
    clearQueues();
    loadWord(0, K, -1);
    applyStimulus(N, 200);
    checkOutput("zero_done", done, 1);
    checkOutput("zero_word", packBits(0, N, 0), 0);
    checkOutput("zero_first", packBits(0, N, 1), 'h4000);
    checkOutput("zero_last", packBits(0, N, 2), 'h0001);

    // Single leading one.
    clearQueues();
    loadWord('b10000, K, -1);
    applyStimulus(N, 200);
    checkOutput("m10000_done", done, 1);
    checkOutput("m10000_parity", packBits(0, N, 0) & 'h3FF, 'h29B);
    checkOutput("m10000_word", packBits(0, N, 0), refCodeword('b10000));

    // All-ones message.
    clearQueues();
    loadWord('b11111, K, -1);
    applyStimulus(N, 200);
    checkOutput("m11111_done", done, 1);
    checkOutput("m11111_word", packBits(0, N, 0), 'h7FFF);

    // Three back-to-back words with no throttling must take exactly 3*N cycles.
    clearQueues();
    for (int w = 0; w < 3; w++) begin
      msgs[w] = int'($urandom_range(31));
      loadWord(msgs[w], K, -1);
    end
    applyStimulus(3 * N, 400);
    checkOutput("b2b_done", done, 1);
    checkOutput("b2b_cycles", cycles, 3 * N);
    for (int w = 0; w < 3; w++) checkOutput("b2b_word", packBits(w * N, N, 0), refCodeword(msgs[w]));

    // 100 random words with random throttling on both sides.
    clearQueues();
    throttle = 1'b1;
    for (int w = 0; w < 100; w++) begin
      msgs[w] = int'($urandom_range(31));
      loadWord(msgs[w], K, -1);
    end
    applyStimulus(100 * N, 30000);
    throttle = 1'b0;
    checkOutput("rand_done", done, 1);
    if (done == 1) begin
      for (int w = 0; w < 100; w++) begin
        checkOutput("rand_word", packBits(w * N, N, 0), refCodeword(msgs[w]));
        checkOutput("rand_syndrome", polyMod(packBits(w * N, N, 0), N), 0);
        checkOutput("rand_first", packBits(w * N, N, 1), 'h4000);
        checkOutput("rand_last", packBits(w * N, N, 2), 'h0001);
      end
    end

    // Assert reset while parity beat 3 is presented, then send a clean word.
    clearQueues();
    loadWord('b10000, K, -1);
    applyStimulus(K + 3, 100);
    checkOutput("abort_reached", done, 1);
    checkOutput("abort_pre_valid", int'(bus.o_valid), 1);
    reset = 1'b1;
    #1;
    checkOutput("abort_o_valid", int'(bus.o_valid), 0);
    checkOutput("abort_o_last", int'(bus.o_last), 0);
    checkOutput("abort_s_ready", int'(bus.s_ready), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    clearQueues();
    loadWord('b10000, K, -1);
    applyStimulus(N, 200);
    checkOutput("clean_done", done, 1);
    checkOutput("clean_word", packBits(0, N, 0), refCodeword('b10000));
    checkOutput("clean_parity", packBits(0, N, 0) & 'h3FF, 'h29B);
    checkOutput("clean_first", packBits(0, N, 1), 'h4000);

`ifdef BCH_ENCODE_SHORTEN_EN
    // A one-bit shortened word: the message is 1, followed at once by parity x^10 mod g.
    clearQueues();
    loadWord(1, 1, 0);
    applyStimulus(P + 1, 100);
    checkOutput("short_done", done, 1);
    checkOutput("short_word", packBits(0, P + 1, 0), 'h537);
    checkOutput("short_syndrome", polyMod(packBits(0, P + 1, 0), P + 1), 0);
    checkOutput("short_last", packBits(0, P + 1, 2), 1);
    checkOutput("short_first", packBits(0, P + 1, 1), 'h400);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
